// File: rtl/syn_updown_mod_counter.sv
// Parametrised synchronous up/down modulo counter with count enable, prescaler,
// clear, clamped parallel load, terminal-count flag and registered wrap pulse.
// Optional wrap event counter enabled by defining SYN_UPDOWN_MOD_COUNTER_WRAPCNT_EN.
module syn_updown_mod_counter #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int PRESCALE = 1,
  parameter int RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
`ifdef SYN_UPDOWN_MOD_COUNTER_WRAPCNT_EN
  ,
  output logic [15:0]      wrap_cnt
`endif
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             w_ps_done;
  logic             w_step;
  logic             w_at_end;
  logic [WIDTH-1:0] w_next_q;
  logic [WIDTH-1:0] w_load_q;

  // Prescaler phase survives en=0 and dir changes; only rst/clr/load restart it.
  generate
    if (PRESCALE > 1) begin : g_ps
      localparam int            PS_W    = $clog2(PRESCALE);
      localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
      logic [PS_W-1:0] r_ps;

      always_ff @(posedge clk) begin
        if (rst || clr || load) begin
          r_ps <= '0;
        end else if (en) begin
          r_ps <= (r_ps == PS_LAST) ? '0 : r_ps + 1'b1;
        end
      end

      assign w_ps_done = (r_ps == PS_LAST);
    end else begin : g_no_ps
      assign w_ps_done = 1'b1;
    end
  endgenerate

  assign w_step   = en && w_ps_done;
  // End of range in the current direction: doubles as the terminal-count flag.
  assign w_at_end = dir ? (r_q == MAX_Q) : (r_q == '0);
  assign w_load_q = ({1'b0, load_val} >= MOD_EXT) ? MAX_Q : load_val;

  always_comb begin
    w_next_q = r_q;
    if (dir) begin
      w_next_q = w_at_end ? '0 : r_q + 1'b1;
    end else begin
      w_next_q = w_at_end ? MAX_Q : r_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q    <= RST_Q;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_q    <= w_load_q;
      r_wrap <= 1'b0;
    end else if (w_step) begin
      r_q    <= w_next_q;
      r_wrap <= w_at_end;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q    = r_q;
  assign tc   = w_at_end;
  assign wrap = r_wrap;

`ifdef SYN_UPDOWN_MOD_COUNTER_WRAPCNT_EN
  logic [15:0] r_wrap_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wrap_cnt <= '0;
    end else if (!load && w_step && w_at_end && (r_wrap_cnt != 16'hFFFF)) begin
      r_wrap_cnt <= r_wrap_cnt + 16'd1;
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`endif

endmodule

// File: tb/tb_syn_updown_mod_counter.sv
// Bench for syn_updown_mod_counter: two configurations driven with shared stimulus,
// checked against an arithmetic reference model through an expected-value queue.
module tb_syn_updown_mod_counter;

  // Instance A: default config (natural overflow). Instance B: odd modulus with prescaler.
  localparam int A_M = 8;
  localparam int A_P = 1;
  localparam int A_R = 0;
  localparam int B_M = 11;
  localparam int B_P = 3;
  localparam int B_R = 3;
  localparam int EXP_W = 43;

  logic       clk;
  logic       rst, clr, load, en, dir;
  logic [3:0] lv;
  logic [2:0] qa;
  logic       tca, wa;
  logic [3:0] qb;
  logic       tcb, wb;
  logic [15:0] ca, cb;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int ma_q = 0, ma_ps = 0, ma_cnt = 0;
  int mb_q = 0, mb_ps = 0, mb_cnt = 0;

  syn_updown_mod_counter #(.WIDTH(3), .MODULUS(A_M), .PRESCALE(A_P), .RST_VAL(A_R)) dut_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lv[2:0]), .q(qa), .tc(tca), .wrap(wa)
`ifdef SYN_UPDOWN_MOD_COUNTER_WRAPCNT_EN
    , .wrap_cnt(ca)
`endif
  );

  syn_updown_mod_counter #(.WIDTH(4), .MODULUS(B_M), .PRESCALE(B_P), .RST_VAL(B_R)) dut_b (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lv), .q(qb), .tc(tcb), .wrap(wb)
`ifdef SYN_UPDOWN_MOD_COUNTER_WRAPCNT_EN
    , .wrap_cnt(cb)
`endif
  );

`ifndef SYN_UPDOWN_MOD_COUNTER_WRAPCNT_EN
  assign ca = '0;
  assign cb = '0;
`endif

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: count in plain integers modulo m, prescale by counting enabled cycles.
  task automatic model_inst(input int m, input int p, input int rv, input int lval,
                            inout int mq, inout int ps, inout int cnt);
    bit wr;
    wr = 1'b0;
    if (rst || clr) begin
      mq = rv; ps = 0; cnt = 0;
    end else if (load) begin
      mq = (lval >= m) ? m - 1 : lval;
      ps = 0;
    end else if (en) begin
      ps = ps + 1;
      if (ps == p) begin
        ps = 0;
        if (dir) begin
          wr = (mq == m - 1);
          mq = (mq + 1) % m;
        end else begin
          wr = (mq == 0);
          mq = (mq + m - 1) % m;
        end
        if (wr && cnt < 65535) cnt = cnt + 1;
      end
    end
  endtask

  function automatic bit model_tc(input int mq, input int m);
    return dir ? (mq == m - 1) : (mq == 0);
  endfunction

  // Driver: apply inputs for the next edge and queue the expected post-edge response.
  task automatic drive(input bit r, input bit c, input bit l, input int lval,
                       input bit e, input bit d);
    int  prev_a_q, prev_b_q;
    int  prev_a_cnt, prev_b_cnt;
    bit  wra, wrb;
    @(negedge clk);
    rst = r; clr = c; load = l; lv = 4'(lval); en = e; dir = d;
    prev_a_q = ma_q; prev_b_q = mb_q;
    prev_a_cnt = ma_cnt; prev_b_cnt = mb_cnt;
    model_inst(A_M, A_P, A_R, lval % 8, ma_q, ma_ps, ma_cnt);
    model_inst(B_M, B_P, B_R, lval, mb_q, mb_ps, mb_cnt);
    // A wrap happened exactly when the step crossed the range boundary.
    wra = !(r || c || l) && (ma_cnt != prev_a_cnt || (prev_a_cnt == 65535 &&
          ((d && prev_a_q == A_M - 1 && ma_q == 0) || (!d && prev_a_q == 0 && ma_q == A_M - 1))));
    wrb = !(r || c || l) && (mb_cnt != prev_b_cnt || (prev_b_cnt == 65535 &&
          ((d && prev_b_q == B_M - 1 && mb_q == 0) || (!d && prev_b_q == 0 && mb_q == B_M - 1))));
    exp_q.push_back({3'(ma_q), model_tc(ma_q, A_M), wra,
                     4'(mb_q), model_tc(mb_q, B_M), wrb,
                     16'(ma_cnt), 16'(mb_cnt)});
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: one response per clock edge, popped and compared after the edge settles.
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("q_a",    16'(qa),  16'(e[42:40]));
        check("tc_a",   16'(tca), 16'(e[39]));
        check("wrap_a", 16'(wa),  16'(e[38]));
        check("q_b",    16'(qb),  16'(e[37:34]));
        check("tc_b",   16'(tcb), 16'(e[33]));
        check("wrap_b", 16'(wb),  16'(e[32]));
`ifdef SYN_UPDOWN_MOD_COUNTER_WRAPCNT_EN
        check("wrap_cnt_a", ca, e[31:16]);
        check("wrap_cnt_b", cb, e[15:0]);
`endif
      end
    end
  end

  // Stimulus
  initial begin
    bit rr, cc, ll, ee, dd;
    rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b1; lv = '0;

    repeat (2) drive(1, 0, 0, 0, 0, 1);
    repeat (10) drive(0, 0, 0, 0, 1, 1);        // up count through a wrap
    repeat (24) drive(0, 0, 0, 0, 1, 0);        // down count through wraps
    drive(0, 1, 0, 0, 0, 1);
    repeat (9) drive(0, 0, 0, 0, 1, 1);         // prescale phase retained across en=0
    repeat (4) drive(0, 0, 0, 0, 0, 1);
    repeat (6) drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 1, 13, 0, 1);                   // clamp on B, truncated 5 on A
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 13, 1, 1);                   // clr beats load
    drive(0, 0, 1, 15, 1, 1);
    drive(1, 0, 1, 13, 1, 1);                   // rst beats load
    drive(0, 0, 1, 4, 0, 1);
    repeat (5) drive(0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 1, 1);                    // reset mid-count
    repeat (4) drive(0, 0, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 0, 1);
    repeat (170) drive(0, 0, 0, 0, 1, 1);       // many wraps for the event counter
    drive(0, 0, 1, 2, 0, 1);                    // load must not clear the event counter
    drive(0, 1, 0, 0, 0, 1);

    dd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 63) == 0);
      cc = ($urandom_range(0, 31) == 0);
      ll = ($urandom_range(0, 15) == 0);
      ee = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) dd = ~dd;
      drive(rr, cc, ll, $urandom_range(0, 15), ee, dd);
    end

    repeat (3) @(negedge clk);
    check("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
